// File: rtl/onehot_decode_pipe.sv
// Index-to-vector decoder feeding a 2-entry output FIFO; result visible 1 cycle after acceptance.
// Backpressure: in_ready drops when both FIFO entries are full. THERMO_MODE_EN enables thermometer decode.
module onehot_decode_pipe #(
    parameter int ENC_W = 3,
    parameter int DEC_W = 2**ENC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ENC_W-1:0] in_enc,
    input  logic             in_en,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DEC_W-1:0] out_dec,
    output logic [15:0]      out_cnt
);

    logic [DEC_W-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;
    logic             r_live;
    logic [15:0]      r_cnt;

    logic             w_push;
    logic             w_pop;
    logic [DEC_W-1:0] w_dec;

    // r_live keeps in_ready low during reset and on the edge where reset releases.
    assign in_ready  = r_live && (r_occ < 2'd2);
    assign out_valid = (r_occ != 2'd0);
    assign out_dec   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_cnt   = r_cnt;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

`ifdef THERMO_MODE_EN
    always_comb begin
        w_dec = '0;
        if (in_en) begin
            if (in_mode) begin
                for (int i = 0; i < DEC_W; i++) begin
                    w_dec[i] = (i <= int'(in_enc));
                end
            end else begin
                w_dec[in_enc] = 1'b1;
            end
        end
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = in_mode;

    always_comb begin
        w_dec = '0;
        if (in_en) begin
            w_dec[in_enc] = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_dec;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'h0000;
        end else if (w_pop) begin
            r_cnt <= r_cnt + 16'h0001;
        end
    end

endmodule

// File: tb/tb_onehot_decode_pipe.sv
// Scoreboard bench for onehot_decode_pipe: default 3-bit instance plus a 4-bit instance for counter wrap.
module tb_onehot_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_en, in_mode;
    logic [2:0]  in_enc;
    logic        out_valid, out_ready;
    logic [7:0]  out_dec;
    logic [15:0] out_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0]  b_in_enc;
    logic [15:0] b_out_dec, b_out_cnt;

    logic [7:0]  exp_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    onehot_decode_pipe #(.ENC_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_enc(in_enc), .in_en(in_en), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_dec(out_dec), .out_cnt(out_cnt)
    );

    onehot_decode_pipe #(.ENC_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_enc(b_in_enc), .in_en(1'b1), .in_mode(1'b0), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_dec(b_out_dec), .out_cnt(b_out_cnt)
    );

    function automatic logic [7:0] model(input logic [2:0] enc, input logic en, input logic mode);
        logic [7:0] v;
        v = 8'h00;
        if (en) begin
`ifdef THERMO_MODE_EN
            if (mode) begin
                for (int i = 0; i <= int'(enc); i++) v[i] = 1'b1;
            end else begin
                v[enc] = 1'b1;
            end
`else
            if (mode || !mode) v[enc] = 1'b1;
`endif
        end
        return v;
    endfunction

    // Drives one cycle of stimulus at the falling edge; records acceptances in the scoreboard.
    task automatic drive(input logic v, input logic [2:0] enc, input logic en, input logic mode,
                         input logic ordy, output logic acc, output logic xf, output logic [7:0] dec);
        @(negedge clk);
        in_valid  = v;
        in_enc    = enc;
        in_en     = en;
        in_mode   = mode;
        out_ready = ordy;
        acc = v && in_ready;
        xf  = out_valid && ordy;
        dec = out_dec;
        if (acc) exp_q.push_back(model(enc, en, mode));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_enc = 3'd0; in_en = 1'b1; in_mode = 1'b0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_enc = 4'd0; b_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, out_dec, out_cnt} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b vld=%b dec=%h cnt=%h, want all 0", in_ready, out_valid, out_dec, out_cnt);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_at_release: got %b want 0", in_ready);
        end
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL no_accept_at_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_sweep();
        logic acc, xf; logic [7:0] dec, e;
        for (int i = 0; i < 9; i++) begin
            drive(i < 8, 3'(i), 1'b1, 1'b0, 1'b1, acc, xf, dec);
            if (i < 8) begin
                vectors++;
                if (!acc) begin miscompares++; $display("FAIL sweep_accept[%0d]: got 0 want 1", i); end
            end
            if (i > 0) begin
                vectors++;
                if (!xf) begin
                    miscompares++; $display("FAIL sweep_latency[%0d]: out_valid got 0 want 1", i);
                end else begin
                    e = exp_q.pop_front();
                    if (dec !== e) begin miscompares++; $display("FAIL sweep_data[%0d]: got %h want %h", i, dec, e); end
                end
            end
        end
        drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, acc, xf, dec);
        vectors++;
        if (out_cnt !== 16'd8 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL sweep_count: got cnt=%0d vld=%b want cnt=8 vld=0", out_cnt, out_valid);
        end
    endtask

    task automatic test_disable();
        logic acc, xf; logic [7:0] dec, e;
        drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b1, acc, xf, dec);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, acc, xf, dec);
        vectors++;
        if (!xf || exp_q.size() == 0) begin
            miscompares++; $display("FAIL disable_valid: out_valid got 0 want 1");
        end else begin
            e = exp_q.pop_front();
            if (dec !== e || dec !== 8'h00) begin miscompares++; $display("FAIL disable_data: got %h want 00", dec); end
        end
        drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, acc, xf, dec);
    endtask

    task automatic test_backpressure();
        logic acc, xf, got1; logic [7:0] dec, e; int n;
        drive(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, acc, xf, dec);
        drive(1'b1, 3'd6, 1'b1, 1'b0, 1'b0, acc, xf, dec);
        drive(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, acc, xf, dec);
        vectors++;
        if (acc !== 1'b0 || exp_q.size() != 2) begin
            miscompares++; $display("FAIL bp_full: in_ready got %b with %0d queued, want 0 with 2", in_ready, exp_q.size());
        end
        drive(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, acc, xf, dec);
        vectors++;
        if (out_valid !== 1'b1 || dec !== 8'h04) begin
            miscompares++; $display("FAIL bp_hold: got vld=%b dec=%h want vld=1 dec=04", out_valid, dec);
        end
        got1 = 1'b0; n = 0;
        for (int c = 0; c < 10 && !(got1 && exp_q.size() == 0); c++) begin
            drive(!got1, 3'd1, 1'b1, 1'b0, 1'b1, acc, xf, dec);
            if (acc) got1 = 1'b1;
            if (xf) begin
                n++;
                vectors++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                if (dec !== e) begin miscompares++; $display("FAIL bp_order[%0d]: got %h want %h", n, dec, e); end
            end
        end
        vectors++;
        if (n != 3 || !got1) begin
            miscompares++; $display("FAIL bp_drain: got %0d transfers want 3 (enc1 accepted=%b)", n, got1);
        end
        drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, acc, xf, dec);
    endtask

    task automatic test_thermo();
        logic acc, xf; logic [7:0] dec, e, want;
`ifdef THERMO_MODE_EN
        want = 8'h1F;
`else
        want = 8'h10;
`endif
        drive(1'b1, 3'd4, 1'b1, 1'b1, 1'b1, acc, xf, dec);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, acc, xf, dec);
        vectors++;
        if (!xf || exp_q.size() == 0) begin
            miscompares++; $display("FAIL thermo_valid: out_valid got 0 want 1");
        end else begin
            e = exp_q.pop_front();
            if (dec !== e || dec !== want) begin miscompares++; $display("FAIL thermo_data: got %h want %h", dec, want); end
        end
        drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, acc, xf, dec);
    endtask

    task automatic test_reset_mid();
        logic acc, xf; logic [7:0] dec, e;
        drive(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, acc, xf, dec);
        drive(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, acc, xf, dec);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, acc, xf, dec);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_full: got rdy=%b vld=%b want rdy=0 vld=1", in_ready, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_dec !== 8'h00 || out_cnt !== 16'h0000) begin
            miscompares++; $display("FAIL rst_mid_clear: got vld=%b dec=%h cnt=%h want 0,00,0000", out_valid, out_dec, out_cnt);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'd7, 1'b1, 1'b0, 1'b1, acc, xf, dec);
        vectors++;
        if (out_valid !== 1'b0 || !acc) begin
            miscompares++; $display("FAIL rst_mid_stale: got vld=%b acc=%b want vld=0 acc=1", out_valid, acc);
        end
        drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, acc, xf, dec);
        vectors++;
        if (!xf || exp_q.size() == 0) begin
            miscompares++; $display("FAIL rst_mid_new: out_valid got 0 want 1");
        end else begin
            e = exp_q.pop_front();
            if (dec !== e || dec !== 8'h80) begin miscompares++; $display("FAIL rst_mid_data: got %h want 80", dec); end
        end
        drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, acc, xf, dec);
    endtask

    task automatic test_cnt_wrap();
        int xfers = 0, bubbles = 0, baddata = 0;
        logic started = 1'b0;
        b_out_ready = 1'b1;
        for (int c = 0; c < 70000 && xfers < 65537; c++) begin
            @(negedge clk);
            b_in_valid = 1'b1;
            b_in_enc   = c[3:0];
            if (b_out_valid) begin
                started = 1'b1;
                if (b_out_dec !== (16'h0001 << (xfers % 16))) baddata++;
                xfers++;
            end else if (started) begin
                bubbles++;
            end
        end
        @(negedge clk);
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        vectors++;
        if (xfers != 65537) begin
            miscompares++; $display("FAIL wrap_timeout: got %0d transfers want 65537", xfers);
        end
        vectors++;
        if (b_out_cnt !== 16'h0001) begin
            miscompares++; $display("FAIL wrap_count: got %h want 0001", b_out_cnt);
        end
        vectors++;
        if (bubbles != 0 || baddata != 0) begin
            miscompares++; $display("FAIL wrap_stream: got %0d bubbles %0d bad data, want 0 and 0", bubbles, baddata);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_disable();
        test_backpressure();
        test_thermo();
        test_reset_mid();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/onehot_decode_pipe.md
ONEHOT_DECODE_PIPE -- requirements
Module: onehot_decode_pipe

Interface
REQ-001 SHALL have parameter ENC_W, default 3, encoded index width; legal range 1..6.
REQ-002 SHALL have parameter DEC_W, default 2**ENC_W, decoded vector width; any other value is illegal.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port in_enc  input  ENC_W  index to decode.
REQ-008 SHALL have port in_en  input  1  0 forces an all-zero decoded vector (write disabled).
REQ-009 SHALL have port in_mode  input  1  0 = one-hot, 1 = thermometer (see REQ-026).
REQ-010 SHALL have port out_valid  output  1  out_dec holds a decoded result.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port out_dec  output  DEC_W  decoded vector.
REQ-013 SHALL have port out_cnt  output  16  count of results transferred downstream.

Function
REQ-014 SHALL decode at acceptance: one-hot => bit in_enc set, all other bits clear; in_en=0 => all bits clear regardless of in_enc/in_mode.
REQ-015 SHALL accept a request when in_valid && in_ready at a rising edge; transfer a result when out_valid && out_ready.
REQ-016 SHALL buffer decoded vectors in a 2-entry FIFO (head/tail pointers, 2-bit occupancy).
REQ-017 SHALL drive in_ready = (occupancy < 2), derived from registers only, with no combinational path from out_ready or in_valid.
REQ-018 SHALL drive out_valid = (occupancy > 0) and out_dec = head entry, both from registers only.
REQ-019 SHALL present an accepted request on out_dec with out_valid high exactly 1 cycle after acceptance when the FIFO was empty.
REQ-020 SHALL hold out_dec and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL, on a simultaneous accept and transfer with occupancy 1, keep occupancy 1 and present the new entry next cycle.
REQ-022 SHALL ignore in_valid while occupancy is 2 (no overwrite, no drop of stored entries).
REQ-023 SHALL wrap the pointers modulo 2 and preserve order across the wrap.
REQ-024 SHALL drive out_dec to all zeros whenever out_valid is 0.
REQ-025 SHALL increment out_cnt by 1 per transfer, wrapping from 16'hFFFF to 16'h0000.

Configuration
REQ-026 SHALL, with THERMO_MODE_EN defined, decode in_mode=1 as thermometer: bits 0..in_enc set, bits above clear (in_enc=0 yields 1).
REQ-027 SHALL, without THERMO_MODE_EN, ignore in_mode and always decode one-hot; port list unchanged.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force occupancy 0, pointers 0, out_valid 0, out_dec 0, out_cnt 0, and in_ready 1 after the first rising edge with rst_n high (in_ready 0 while rst_n=0).
REQ-029 SHALL discard buffered entries on reset mid-operation; no result is presented after reset release until a new request is accepted.
REQ-030 SHALL not accept requests in the cycle rst_n deasserts.

Verification
REQ-031 Bench SHALL cover sweep in_enc 0..7, in_en=1, in_mode=0, out_ready=1 -> out_dec 8'h01,8'h02,...,8'h80 each 1 cycle after acceptance; out_cnt=8.
REQ-032 Bench SHALL cover in_enc=3'd5, in_en=0 -> out_dec=8'h00 with out_valid=1.
REQ-033 Bench SHALL cover out_ready=0, push enc 2, 6, 1 -> in_ready low after 2 accepts, enc 1 held off; release -> 8'h04, 8'h40, then 8'h02 after enc 1 is accepted, in order.
REQ-034 Bench SHALL cover THERMO_MODE_EN defined, in_mode=1, in_enc=3'd4 -> out_dec=8'h1F; undefined -> 8'h10.
REQ-035 Bench SHALL cover occupancy 2, then rst_n pulsed low 1 cycle -> out_valid=0, out_dec=0, out_cnt=0 immediately; next accept of enc 7 yields 8'h80.
REQ-036 Bench SHALL cover ENC_W=4, continuous accept/transfer for 65537 transfers -> out_cnt=16'h0001, no bubbles after the first result.
